// File: rtl/pipe_ctrl.sv
// Pipeline control: PC and pipeline-register ld/clr, with memory-wait freeze, load-use bubble and branch flush.
// Latency: ld/clr are combinational (zero cycles); counters and err update on the next rising edge.
// Backpressure: mem_ready low freezes PC..EX/MEM and bubbles WB. PIPE_CTRL_TIMEOUT_EN adds the memory-wait timeout.
module pipe_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_valid,
    input  logic                  id_src2_valid,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_ld,
    output logic                  ifid_ld,
    output logic                  idex_ld,
    output logic                  exmem_ld,
    output logic                  memwb_ld,
    output logic                  ifid_clr,
    output logic                  idex_clr,
    output logic                  memwb_clr,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic                  err,
    output logic                  mem_abort
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             freeze;
    logic             branch;
    logic             load_use;
    logic             lu_hit;
    logic             timeout_hit;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Load-use hazard: EX holds a load whose destination is a source actually read in ID.
    assign lu_hit = ex_mem_read &
                    ((id_src1_valid & (id_src1 == ex_dest)) |
                     (id_src2_valid & (id_src2 == ex_dest)));

    // Freeze wins over everything; a pending branch or hazard simply waits in place.
    assign freeze   = (state == MEM_WAIT) | (mem_req & ~mem_ready);
    assign branch   = ~freeze & ex_branch_taken;
    assign load_use = ~freeze & ~ex_branch_taken & lu_hit;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    // The ready cycle beats the limit cycle, so only a still-missing ready times out.
    assign timeout_hit = (state == MEM_WAIT) & ~mem_ready &
                         (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // Wait counter held at zero outside MEM_WAIT, so it starts at zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != MEM_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err       = err_q;
    assign mem_abort = timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign mem_abort   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter MEM_WAIT on an unanswered request, leave on ready or timeout.
    always_comb begin
        state_nxt = state;
        if (state == RUN) begin
            if (mem_req & ~mem_ready) begin
                state_nxt = MEM_WAIT;
            end
        end else begin
            if (mem_ready | timeout_hit) begin
                state_nxt = RUN;
            end
        end
    end

    // Register controls: freeze, then branch flush, then load-use bubble, else advance.
    always_comb begin
        pc_ld     = 1'b1;
        ifid_ld   = 1'b1;
        idex_ld   = 1'b1;
        exmem_ld  = 1'b1;
        memwb_ld  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        memwb_clr = 1'b0;
        if (freeze) begin
            pc_ld     = 1'b0;
            ifid_ld   = 1'b0;
            idex_ld   = 1'b0;
            exmem_ld  = 1'b0;
            memwb_clr = 1'b1;
        end else if (branch) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (load_use) begin
            pc_ld    = 1'b0;
            ifid_ld  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    // Saturating stall counter: freeze and load-use cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((freeze | load_use) && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // Saturating flush counter: branch cycles that were not frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q <= '0;
        end else if (branch && (flush_q != {CNT_W{1'b1}})) begin
            flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic against a table-driven reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Built with CNT_W=4 and TIMEOUT=8 so saturation and timeout are reachable quickly.
module tb_pipe_ctrl;

    localparam int AW   = 4;
    localparam int CW   = 4;
    localparam int TO   = 8;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int K_NORMAL = 0;
    localparam int K_FREEZE = 1;
    localparam int K_FLUSH  = 2;
    localparam int K_BUBBLE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] id_src1 = '0, id_src2 = '0, ex_dest = '0;
    logic          id_src1_valid = 1'b0, id_src2_valid = 1'b0;
    logic          ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0;
    logic          pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld;
    logic          ifid_clr, idex_clr, memwb_clr, err, mem_abort;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
        .ex_dest(ex_dest), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld), .exmem_ld(exmem_ld), .memwb_ld(memwb_ld),
        .ifid_clr(ifid_clr), .idex_clr(idex_clr), .memwb_clr(memwb_clr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .err(err), .mem_abort(mem_abort)
    );

    always #5 clk = ~clk;

    wire [9:0] act = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld,
                      ifid_clr, idex_clr, memwb_clr, mem_abort, err};

    int checks   = 0;
    int failures = 0;

    // Reference model: "is a memory access outstanding", how long it has waited, and the tallies.
    bit m_wait;
    int m_waited;
    int m_stall;
    int m_flush;
    bit m_err;

    function automatic int kind_now();
        bit hit;
        hit = ex_mem_read && ((id_src1_valid && id_src1 == ex_dest) ||
                              (id_src2_valid && id_src2 == ex_dest));
        if (m_wait || (mem_req && !mem_ready)) return K_FREEZE;
        if (ex_branch_taken)                   return K_FLUSH;
        if (hit)                               return K_BUBBLE;
        return K_NORMAL;
    endfunction

    function automatic bit abort_now();
        return TO_EN && m_wait && (m_waited == TO - 1) && !mem_ready;
    endfunction

    // Expected {pc,ifid,idex,exmem,memwb ld, ifid,idex,memwb clr, abort, err}.
    function automatic logic [9:0] exp_vec();
        logic [7:0] ctl;
        case (kind_now())
            K_FREEZE: ctl = 8'b00001_001;
            K_FLUSH:  ctl = 8'b11111_110;
            K_BUBBLE: ctl = 8'b00111_010;
            default:  ctl = 8'b11111_000;
        endcase
        return {ctl, abort_now(), m_err};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 0;
    endtask

    // Apply the effect of the current cycle, as seen at the coming rising edge.
    task automatic model_step();
        int k;
        bit ab;
        k  = kind_now();
        ab = abort_now();
        if ((k == K_FREEZE || k == K_BUBBLE) && m_stall < MAXC) m_stall++;
        if (k == K_FLUSH && m_flush < MAXC) m_flush++;
        if (ab) m_err = 1;
        if (m_wait) begin
            if (mem_ready || ab) m_wait = 0;
            else m_waited++;
        end else if (mem_req && !mem_ready) begin
            m_wait   = 1;
            m_waited = 0;
        end
    endtask

    task automatic drive(bit emr, logic [AW-1:0] dest, logic [AW-1:0] s1, bit s1v,
                         logic [AW-1:0] s2, bit s2v, bit bt, bit req, bit rdy);
        ex_mem_read = emr; ex_dest = dest;
        id_src1 = s1; id_src1_valid = s1v;
        id_src2 = s2; id_src2_valid = s2v;
        ex_branch_taken = bt; mem_req = req; mem_ready = rdy;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL reset_pre cyc=%0d got=%b exp=%b", i, act, exp_vec());
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 4'd2) begin
            failures++;
            $display("FAIL reset_pre_stall got=%0d exp=2", stall_cnt);
        end
        // Reset asserted mid-cycle while MEM_WAIT with the request still pending.
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({stall_cnt, flush_cnt, err, mem_abort} !== 10'd0) begin
            failures++;
            $display("FAIL reset_async_regs got=%b exp=0", {stall_cnt, flush_cnt, err, mem_abort});
        end
        mem_req = 1'b0;
        #1;
        checks++;
        if (act !== 10'b11111_000_00) begin
            failures++;
            $display("FAIL reset_async_state got=%b exp=1111100000", act);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (act !== 10'b11111_000_00 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_quiet got=%b/%0d exp=1111100000/0", act, stall_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive(1, 3, 5, 1, 3, 1, 0, 0, 0);
                1: drive(0, 3, 5, 1, 3, 1, 0, 0, 0);
                2: drive(1, 3, 5, 1, 3, 0, 0, 0, 0);
                default: drive(1, 6, 6, 1, 2, 1, 0, 0, 0);
            endcase
            #1;
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL load_use row=%0d got=%b exp=%b", i, act, exp_vec());
            end
            tick();
        end
        checks++;
        if (stall_cnt !== 4'd2 || stall_cnt !== CW'(m_stall)) begin
            failures++;
            $display("FAIL load_use_stall got=%0d exp=2", stall_cnt);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        drive(1, 3, 3, 1, 3, 1, 1, 0, 0);
        #1;
        checks++;
        if (act !== exp_vec() || act !== 10'b11111_110_00) begin
            failures++;
            $display("FAIL branch_lu got=%b exp=%b", act, exp_vec());
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL branch_lu_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_wait();
        int bubbles = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, i < 4, i == 3);
            #1;
            bubbles += int'(memwb_clr);
            checks++;
            if (act !== exp_vec()) begin
                failures++;
                $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, act, exp_vec());
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bubbles != 4 || stall_cnt !== 4'd4 || flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL mem_wait_cnt got=%0d/%0d/%0d exp=4/4/1", bubbles, stall_cnt, flush_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (act !== exp_vec() || stall_cnt !== CW'(m_stall)) begin
                failures++;
                $display("FAIL sat cyc=%0d got=%b/%0d exp=%b/%0d", i, act, stall_cnt, exp_vec(), m_stall);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL sat_value got=%0d exp=15", stall_cnt);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (stall_cnt !== 4'd15 || act[9:2] !== 8'b11111_000) begin
            failures++;
            $display("FAIL sat_hold got=%0d/%b exp=15/11111000", stall_cnt, act[9:2]);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int pulses;
        for (int run = 0; run < 2; run++) begin
            pulses = 0;
            do_reset();
            for (int i = 0; i < 12; i++) begin
                if (run == 0) drive(0, 0, 0, 0, 0, 0, 0, i < 9, i == 10);
                else          drive(0, 0, 0, 0, 0, 0, 0, i < 8, i == 8);
                #1;
                pulses += int'(mem_abort);
                checks++;
                if (act !== exp_vec()) begin
                    failures++;
                    $display("FAIL timeout run=%0d cyc=%0d got=%b exp=%b", run, i, act, exp_vec());
                end
                tick();
            end
            #1;
            checks++;
            if (pulses != ((run == 0 && TO_EN) ? 1 : 0) || err !== (run == 0 && TO_EN)
                || act[9:2] !== 8'b11111_000) begin
                failures++;
                $display("FAIL timeout_end run=%0d got=pulses %0d err %b ctl %b", run, pulses, err, act[9:2]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), 1'($urandom),
                  AW'($urandom_range(0, 3)), 1'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, 1'($urandom));
            #1;
            checks++;
            if (act !== exp_vec() || stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b/%0d/%0d exp=%b/%0d/%0d",
                         i, act, stall_cnt, flush_cnt, exp_vec(), m_stall, m_flush);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_branch_lu();
        test_mem_wait();
        test_saturation();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
